// File: rtl/sd_data_pkg.sv
// Shared types and constants for the SD data-path master: FSM state encoding
// and interrupt-status bit positions.
package sd_data_pkg;

    localparam int STATUS_W  = 5;
    localparam int INT_CC    = 0;
    localparam int INT_CCRCE = 1;
    localparam int INT_CFE   = 2;
    localparam int INT_CTE   = 3;
    localparam int INT_EI    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_WAIT = 3'd1,
        ST_START   = 3'd2,
        ST_ACK     = 3'd3,
        ST_DATA    = 3'd4,
        ST_NEXT    = 3'd5,
        ST_STOP    = 3'd6,
        ST_ABORT   = 3'd7
    } sd_state_t;

    function automatic logic [STATUS_W-1:0] status_bit(input int idx);
        logic [STATUS_W-1:0] mask;
        mask      = {STATUS_W{1'b0}};
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/sd_data_timeout.sv
// Per-block data timeout counter: clears on request, counts while enabled,
// saturates at all-ones and flags the edge on which it reaches the limit.
module sd_data_timeout #(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_r;
    logic [TIMEOUT_W-1:0] count_inc_s;

    // Saturating next count value.
    always_comb begin
        count_inc_s = count_r;
        if (count_r == {TIMEOUT_W{1'b1}}) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + TIMEOUT_W'(1'b1);
        end
    end

    // Expiry fires on the cycle whose edge brings the counter up to the limit.
    assign expired = en && (timeout != {TIMEOUT_W{1'b0}}) && (count_inc_s >= timeout);

    // Counter register.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            count_r <= {TIMEOUT_W{1'b0}};
        end else if (clr) begin
            count_r <= {TIMEOUT_W{1'b0}};
        end else if (en) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sd_data_master_mb.sv
// Multi-block SD data-transfer master sequencing the serial host per block.
// Optional automatic stop command: define SD_DATA_MASTER_AUTO_STOP_EN.
module sd_data_master_mb
    import sd_data_pkg::*;
#(
    parameter int TIMEOUT_W = 24,
    parameter int BLKCNT_W  = 16
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic                 start_tx_i,
    input  logic                 start_rx_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [BLKCNT_W-1:0]  blk_cnt_i,
    output logic                 d_write_o,
    output logic                 d_read_o,
    input  logic                 tx_fifo_empty_i,
    input  logic                 rx_fifo_full_i,
    input  logic                 xfr_complete_i,
    input  logic                 crc_ok_i,
    output logic [STATUS_W-1:0]  int_status_o,
    input  logic                 int_status_rst_i,
    output logic [BLKCNT_W-1:0]  blk_done_o,
    output logic                 busy_o,
    output logic                 stop_req_o,
    input  logic                 stop_ack_i
);

    sd_state_t             state_r, state_next_s;
    logic                  dir_tx_r, dir_tx_next_s;
    logic [BLKCNT_W-1:0]   blk_cnt_r, blk_cnt_next_s;
    logic [BLKCNT_W-1:0]   blk_done_r, blk_done_next_s;
    logic [BLKCNT_W-1:0]   blk_done_inc_s, blk_cnt_eff_s;
    logic                  d_write_r, d_write_next_s;
    logic                  d_read_r, d_read_next_s;
    logic                  crc_r, crc_next_s;
    logic                  xfr_prev_r;
    logic                  busy_r;
    logic [STATUS_W-1:0]   int_status_r, status_set_s;
    logic                  tmo_clr_s, tmo_en_s, tmo_expired_s;
    logic                  xfr_rise_s, fifo_err_s;
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
    logic                  stop_req_r, stop_req_next_s;
    logic                  multi_s;
`else
    logic                  unused_stop_ack_s;
`endif

    assign blk_cnt_eff_s  = (blk_cnt_i == {BLKCNT_W{1'b0}}) ? BLKCNT_W'(1'b1) : blk_cnt_i;
    assign blk_done_inc_s = blk_done_r + BLKCNT_W'(1'b1);
    assign xfr_rise_s     = xfr_complete_i & ~xfr_prev_r;
    assign fifo_err_s     = dir_tx_r ? tx_fifo_empty_i : rx_fifo_full_i;
    assign tmo_en_s       = (state_r == ST_DATA);
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
    assign multi_s        = (blk_cnt_r > BLKCNT_W'(1'b1));
`else
    assign unused_stop_ack_s = stop_ack_i;
`endif

    sd_data_timeout #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
        .sd_clk  (sd_clk),
        .rst     (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .timeout (timeout_i),
        .expired (tmo_expired_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_next_s    = state_r;
        dir_tx_next_s   = dir_tx_r;
        blk_cnt_next_s  = blk_cnt_r;
        blk_done_next_s = blk_done_r;
        d_write_next_s  = d_write_r;
        d_read_next_s   = d_read_r;
        crc_next_s      = crc_r;
        status_set_s    = {STATUS_W{1'b0}};
        tmo_clr_s       = 1'b0;
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
        stop_req_next_s = stop_req_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_tx_i && !start_rx_i) begin
                    dir_tx_next_s   = 1'b1;
                    blk_cnt_next_s  = blk_cnt_eff_s;
                    blk_done_next_s = {BLKCNT_W{1'b0}};
                    state_next_s    = ST_TX_WAIT;
                end else if (start_rx_i && !start_tx_i) begin
                    dir_tx_next_s   = 1'b0;
                    blk_cnt_next_s  = blk_cnt_eff_s;
                    blk_done_next_s = {BLKCNT_W{1'b0}};
                    state_next_s    = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_fifo_empty_i) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_TX_WAIT;
                end
            end
            ST_START: begin
                d_write_next_s = dir_tx_r;
                d_read_next_s  = ~dir_tx_r;
                state_next_s   = ST_ACK;
            end
            ST_ACK: begin
                // The host drops xfr_complete_i once it has taken the request.
                if (!xfr_complete_i) begin
                    d_write_next_s = 1'b0;
                    d_read_next_s  = 1'b0;
                    tmo_clr_s      = 1'b1;
                    state_next_s   = ST_DATA;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            ST_DATA: begin
                if (xfr_rise_s) begin
                    crc_next_s   = crc_ok_i;
                    state_next_s = ST_NEXT;
                end else if (fifo_err_s) begin
                    status_set_s   = status_bit(INT_CFE) | status_bit(INT_EI);
                    d_write_next_s = 1'b1;
                    d_read_next_s  = 1'b1;
                    state_next_s   = ST_ABORT;
                end else if (tmo_expired_s) begin
                    status_set_s   = status_bit(INT_CTE) | status_bit(INT_EI);
                    d_write_next_s = 1'b1;
                    d_read_next_s  = 1'b1;
                    state_next_s   = ST_ABORT;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_NEXT: begin
                if (crc_r) begin
                    blk_done_next_s = blk_done_inc_s;
                    if (blk_done_inc_s == blk_cnt_r) begin
                        status_set_s = status_bit(INT_CC);
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
                        if (multi_s) begin
                            stop_req_next_s = 1'b1;
                            state_next_s    = ST_STOP;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
`else
                        state_next_s = ST_IDLE;
`endif
                    end else if (dir_tx_r) begin
                        state_next_s = ST_TX_WAIT;
                    end else begin
                        state_next_s = ST_START;
                    end
                end else begin
                    status_set_s = status_bit(INT_CCRCE) | status_bit(INT_EI);
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
                    stop_req_next_s = 1'b1;
                    state_next_s    = ST_STOP;
`else
                    state_next_s = ST_IDLE;
`endif
                end
            end
            ST_ABORT: begin
                if (xfr_complete_i) begin
                    d_write_next_s = 1'b0;
                    d_read_next_s  = 1'b0;
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
                    stop_req_next_s = 1'b1;
                    state_next_s    = ST_STOP;
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_ABORT;
                end
            end
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
            ST_STOP: begin
                if (stop_ack_i) begin
                    stop_req_next_s = 1'b0;
                    state_next_s    = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
`endif
            default: begin
                d_write_next_s = 1'b0;
                d_read_next_s  = 1'b0;
                state_next_s   = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; status set wins over clear.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            dir_tx_r     <= 1'b0;
            blk_cnt_r    <= {BLKCNT_W{1'b0}};
            blk_done_r   <= {BLKCNT_W{1'b0}};
            d_write_r    <= 1'b0;
            d_read_r     <= 1'b0;
            crc_r        <= 1'b0;
            xfr_prev_r   <= 1'b0;
            busy_r       <= 1'b0;
            int_status_r <= {STATUS_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            dir_tx_r     <= dir_tx_next_s;
            blk_cnt_r    <= blk_cnt_next_s;
            blk_done_r   <= blk_done_next_s;
            d_write_r    <= d_write_next_s;
            d_read_r     <= d_read_next_s;
            crc_r        <= crc_next_s;
            xfr_prev_r   <= xfr_complete_i;
            busy_r       <= (state_next_s != ST_IDLE);
            int_status_r <= (int_status_rst_i ? {STATUS_W{1'b0}} : int_status_r) | status_set_s;
        end
    end

`ifdef SD_DATA_MASTER_AUTO_STOP_EN
    // Stop-command request register.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            stop_req_r <= 1'b0;
        end else begin
            stop_req_r <= stop_req_next_s;
        end
    end
    assign stop_req_o = stop_req_r;
`else
    assign stop_req_o = 1'b0;
`endif

    assign d_write_o    = d_write_r;
    assign d_read_o     = d_read_r;
    assign int_status_o = int_status_r;
    assign blk_done_o   = blk_done_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_sd_data_master_mb.sv
// Directed self-checking bench for sd_data_master_mb (default parameters).
// Extra stop-command checks are compiled in with SD_DATA_MASTER_AUTO_STOP_EN.
module tb_sd_data_master_mb;

    logic        sd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_tx_i = 1'b0;
    logic        start_rx_i = 1'b0;
    logic [23:0] timeout_i = 24'd0;
    logic [15:0] blk_cnt_i = 16'd0;
    logic        d_write_o;
    logic        d_read_o;
    logic        tx_fifo_empty_i = 1'b0;
    logic        rx_fifo_full_i = 1'b0;
    logic        xfr_complete_i = 1'b1;
    logic        crc_ok_i = 1'b1;
    logic [4:0]  int_status_o;
    logic        int_status_rst_i = 1'b0;
    logic [15:0] blk_done_o;
    logic        busy_o;
    logic        stop_req_o;
    logic        stop_ack_i = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    sd_data_master_mb dut (
        .sd_clk           (sd_clk),
        .rst              (rst),
        .start_tx_i       (start_tx_i),
        .start_rx_i       (start_rx_i),
        .timeout_i        (timeout_i),
        .blk_cnt_i        (blk_cnt_i),
        .d_write_o        (d_write_o),
        .d_read_o         (d_read_o),
        .tx_fifo_empty_i  (tx_fifo_empty_i),
        .rx_fifo_full_i   (rx_fifo_full_i),
        .xfr_complete_i   (xfr_complete_i),
        .crc_ok_i         (crc_ok_i),
        .int_status_o     (int_status_o),
        .int_status_rst_i (int_status_rst_i),
        .blk_done_o       (blk_done_o),
        .busy_o           (busy_o),
        .stop_req_o       (stop_req_o),
        .stop_ack_i       (stop_ack_i)
    );

    always #5 sd_clk = ~sd_clk;

    // Rising-edge counters for the host request lines.
    always @(posedge sd_clk) begin
        if (d_write_o && !wr_prev) wr_pulses = wr_pulses + 1;
        if (d_read_o && !rd_prev) rd_pulses = rd_pulses + 1;
        wr_prev = d_write_o;
        rd_prev = d_read_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sd_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_status();
        int_status_rst_i = 1'b1;
        tick(1);
        int_status_rst_i = 1'b0;
        chk("status_clear", 32'(int_status_o), 32'h00);
    endtask

    // One block: wait for the request, ack it, hold busy 3 cycles, complete.
    task automatic run_block(input logic tx, input logic crc);
        int n;
        n = 0;
        while (((tx ? d_write_o : d_read_o) !== 1'b1) && (n < 10)) begin
            tick(1);
            n = n + 1;
        end
        chk("req_assert", 32'(tx ? d_write_o : d_read_o), 32'h1);
        xfr_complete_i = 1'b0;
        tick(1);
        chk("req_release", 32'({d_write_o, d_read_o}), 32'h0);
        tick(3);
        crc_ok_i       = crc;
        xfr_complete_i = 1'b1;
        tick(1);
        crc_ok_i = 1'b1;
        tick(1);
    endtask

    // Ending that passes through STOP when the auto-stop build is selected.
    task automatic end_stop();
`ifdef SD_DATA_MASTER_AUTO_STOP_EN
        chk("stop_req_set", 32'(stop_req_o), 32'h1);
        stop_ack_i = 1'b1;
        tick(1);
        stop_ack_i = 1'b0;
        chk("stop_req_clr", 32'(stop_req_o), 32'h0);
`else
        chk("stop_req_tied", 32'(stop_req_o), 32'h0);
`endif
    endtask

    initial begin
        int  wr0, rd0, n;
        logic both_seen;

        // Reset state
        tick(2);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_req", 32'({d_write_o, d_read_o}), 32'h0);
        chk("rst_status", 32'(int_status_o), 32'h00);
        chk("rst_blk_done", 32'(blk_done_o), 32'h0);
        rst = 1'b0;
        tick(1);

        // TX, three blocks, all CRC good
        wr0        = wr_pulses;
        timeout_i  = 24'd100;
        blk_cnt_i  = 16'd3;
        start_tx_i = 1'b1;
        tick(1);
        start_tx_i = 1'b0;
        chk("tx_busy", 32'(busy_o), 32'h1);
        run_block(1'b1, 1'b1);
        chk("tx_blk1", 32'(blk_done_o), 32'h1);
        run_block(1'b1, 1'b1);
        chk("tx_blk2", 32'(blk_done_o), 32'h2);
        run_block(1'b1, 1'b1);
        chk("tx_blk3", 32'(blk_done_o), 32'h3);
        chk("tx_status", 32'(int_status_o), 32'h01);
        end_stop();
        chk("tx_idle", 32'(busy_o), 32'h0);
        chk("tx_pulses", 32'(wr_pulses - wr0), 32'h3);
        clear_status();

        // RX, one block, CRC error
        rd0        = rd_pulses;
        blk_cnt_i  = 16'd1;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        run_block(1'b0, 1'b0);
        chk("crc_blk_done", 32'(blk_done_o), 32'h0);
        chk("crc_status", 32'(int_status_o), 32'h12);
        end_stop();
        chk("crc_idle", 32'(busy_o), 32'h0);
        chk("crc_pulses", 32'(rd_pulses - rd0), 32'h1);
        clear_status();

        // Simultaneous start requests are ignored
        start_tx_i = 1'b1;
        start_rx_i = 1'b1;
        tick(1);
        start_tx_i = 1'b0;
        start_rx_i = 1'b0;
        chk("both_start_ignored", 32'(busy_o), 32'h0);

        // RX with block count 0 behaves as one block
        blk_cnt_i  = 16'd0;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        run_block(1'b0, 1'b1);
        chk("cnt0_blk_done", 32'(blk_done_o), 32'h1);
        chk("cnt0_status", 32'(int_status_o), 32'h01);
        chk("cnt0_idle", 32'(busy_o), 32'h0);
        clear_status();

        // TX FIFO underrun in DATA; clear coincides with the set
        blk_cnt_i  = 16'd1;
        start_tx_i = 1'b1;
        tick(1);
        start_tx_i = 1'b0;
        tick(2);
        chk("cfe_ack", 32'(d_write_o), 32'h1);
        xfr_complete_i = 1'b0;
        tick(2);
        tx_fifo_empty_i  = 1'b1;
        int_status_rst_i = 1'b1;
        tick(1);
        tx_fifo_empty_i  = 1'b0;
        int_status_rst_i = 1'b0;
        chk("cfe_abort_req", 32'({d_write_o, d_read_o}), 32'h3);
        chk("cfe_set_wins", 32'(int_status_o), 32'h14);
        tick(3);
        chk("cfe_abort_hold", 32'({d_write_o, d_read_o}), 32'h3);
        xfr_complete_i = 1'b1;
        tick(1);
        chk("cfe_abort_release", 32'({d_write_o, d_read_o}), 32'h0);
        end_stop();
        chk("cfe_idle", 32'(busy_o), 32'h0);
        chk("cfe_status", 32'(int_status_o), 32'h14);
        clear_status();

        // RX timeout of 100 cycles with the host never completing
        timeout_i  = 24'd100;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        tick(1);
        xfr_complete_i = 1'b0;
        tick(1);
        n = 0;
        while (!(d_write_o && d_read_o) && (n < 200)) begin
            tick(1);
            n = n + 1;
        end
        chk("tmo_latency", 32'(n), 32'd100);
        chk("tmo_status_abort", 32'(int_status_o), 32'h18);
        xfr_complete_i = 1'b1;
        tick(1);
        end_stop();
        chk("tmo_idle", 32'(busy_o), 32'h0);
        chk("tmo_status", 32'(int_status_o), 32'h18);
        clear_status();

        // Timeout 0 disables expiry
        timeout_i  = 24'd0;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        tick(1);
        xfr_complete_i = 1'b0;
        tick(1);
        both_seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (d_write_o && d_read_o) both_seen = 1'b1;
        end
        chk("notmo_no_abort", 32'(both_seen), 32'h0);
        chk("notmo_busy", 32'(busy_o), 32'h1);
        chk("notmo_status", 32'(int_status_o), 32'h00);
        xfr_complete_i = 1'b1;
        tick(2);
        chk("notmo_done", 32'(int_status_o), 32'h01);
        chk("notmo_idle", 32'(busy_o), 32'h0);

`ifdef SD_DATA_MASTER_AUTO_STOP_EN
        // Two-block RX success holds the stop request until acknowledged
        blk_cnt_i  = 16'd2;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        run_block(1'b0, 1'b1);
        run_block(1'b0, 1'b1);
        chk("stop_blk_done", 32'(blk_done_o), 32'h2);
        tick(3);
        chk("stop_hold", 32'(stop_req_o), 32'h1);
        chk("stop_busy", 32'(busy_o), 32'h1);
        stop_ack_i = 1'b1;
        tick(1);
        stop_ack_i = 1'b0;
        chk("stop_released", 32'(stop_req_o), 32'h0);
        chk("stop_idle", 32'(busy_o), 32'h0);
`endif

        // Reset in the middle of the second block's DATA phase
        blk_cnt_i  = 16'd2;
        start_rx_i = 1'b1;
        tick(1);
        start_rx_i = 1'b0;
        run_block(1'b0, 1'b1);
        chk("mid_blk1", 32'(blk_done_o), 32'h1);
        tick(1);
        chk("mid_ack", 32'(d_read_o), 32'h1);
        xfr_complete_i = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_req", 32'({d_write_o, d_read_o}), 32'h0);
        chk("mid_rst_status", 32'(int_status_o), 32'h00);
        chk("mid_rst_blk_done", 32'(blk_done_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_stop", 32'(stop_req_o), 32'h0);
        rst            = 1'b0;
        xfr_complete_i = 1'b1;
        tick(2);
        chk("post_rst_idle", 32'(busy_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
